// File: rtl/multi_toggle_gen.sv
// Multi-channel square-wave stimulus source: CH independent toggling outputs,
// each with its own captured half-period, running for a captured cycle count.

module multi_toggle_ch #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [PW-1:0] per_i,
    output logic          out_o
);
    logic [PW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (clr_i) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (en_i && per_i != '0) begin
            // cnt_q < per_i always holds, so the counter never wraps
            if (cnt_q == per_i - PW'(1)) begin
                cnt_d = '0;
                out_d = ~out_q;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

module multi_toggle_gen #(
    parameter int CH = 4,
    parameter int PW = 8,
    parameter int LW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CH*PW-1:0] period,
    input  logic [LW-1:0]    run_len,
    output logic [CH-1:0]    out,
    output logic             busy,
    output logic             done,
    output logic [LW-1:0]    elapsed
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CH-1:0][PW-1:0]  per_q, per_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          elapsed_q, elapsed_d;
    logic                   ch_clr, ch_en;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        len_d     = len_q;
        elapsed_d = elapsed_q;
        ch_clr    = 1'b0;
        ch_en     = 1'b0;
        case (state_q)
            S_RUN: begin
                // stop beats completion; elapsed keeps the aborted count
                if (stop) begin
                    state_d = S_IDLE;
                    ch_clr  = 1'b1;
                end else begin
                    ch_en     = 1'b1;
                    elapsed_d = elapsed_q + LW'(1);
                    if (elapsed_q == len_q - LW'(1))
                        state_d = S_DONE;
                end
            end
            default: begin
                if (stop) begin
                    state_d = S_IDLE;
                    ch_clr  = 1'b1;
                end else if (start) begin
                    per_d     = period;
                    len_d     = run_len;
                    elapsed_d = '0;
                    ch_clr    = 1'b1;
                    state_d   = (run_len == '0) ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            per_q     <= '0;
            len_q     <= '0;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            len_q     <= len_d;
            elapsed_q <= elapsed_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        multi_toggle_ch #(.PW(PW)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .clr_i (ch_clr),
            .en_i  (ch_en),
            .per_i (per_q[i]),
            .out_o (out[i])
        );
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign elapsed = elapsed_q;
endmodule

// File: tb/tb_multi_toggle_gen.sv
// Directed bench: stimulus pushes cycle-tagged expectations, a negedge monitor
// pops and compares them against out/busy/done/elapsed.

module tb_multi_toggle_gen;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [31:0] period;
    logic [15:0] run_len;
    logic [3:0]  out;
    logic        busy, done;
    logic [15:0] elapsed;

    multi_toggle_gen #(.CH(4), .PW(8), .LW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .period  (period),
        .run_len (run_len),
        .out     (out),
        .busy    (busy),
        .done    (done),
        .elapsed (elapsed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        string       nm;
        logic [3:0]  o;
        logic        b;
        logic        d;
        logic [15:0] e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic expect_at(input int c, input string nm, input logic [3:0] o,
                             input logic b, input logic d, input logic [15:0] e);
        exp_t x;
        x.c = c; x.nm = nm; x.o = o; x.b = b; x.d = d; x.e = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (x.c < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", x.nm, x.c, cyc);
            end else if ({out, busy, done, elapsed} !== {x.o, x.b, x.d, x.e}) begin
                failures++;
                $display("FAIL %s @%0d: got out=%b busy=%b done=%b elapsed=%0d, want out=%b busy=%b done=%b elapsed=%0d",
                         x.nm, cyc, out, busy, done, elapsed, x.o, x.b, x.d, x.e);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [31:0] P_BASIC = 32'h05040302;
    int T;

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; period = P_BASIC; run_len = 16'd5;

        // reset with start held high
        for (int k = 1; k <= 5; k++) expect_at(k, "reset", 4'b0, 1'b0, 1'b0, 16'd0);
        tick(3);
        rst = 1'b0; start = 1'b0;
        tick(2);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1; T = cyc + 1;
        expect_at(T,     "start_stop_idle", 4'b0, 1'b0, 1'b0, 16'd0);
        expect_at(T + 1, "start_stop_idle2", 4'b0, 1'b0, 1'b0, 16'd0);
        tick(); start = 1'b0; stop = 1'b0; tick();

        // basic run; inputs changed mid-run must not matter
        start = 1'b1; period = P_BASIC; run_len = 16'd100; T = cyc + 1;
        expect_at(T,       "basic_T0",   4'b0000, 1'b1, 1'b0, 16'd0);
        expect_at(T + 1,   "basic_T1",   4'b0000, 1'b1, 1'b0, 16'd1);
        expect_at(T + 2,   "basic_T2",   4'b0001, 1'b1, 1'b0, 16'd2);
        expect_at(T + 3,   "basic_T3",   4'b0011, 1'b1, 1'b0, 16'd3);
        expect_at(T + 4,   "basic_T4",   4'b0110, 1'b1, 1'b0, 16'd4);
        expect_at(T + 5,   "basic_T5",   4'b1110, 1'b1, 1'b0, 16'd5);
        expect_at(T + 99,  "basic_T99",  4'b1011, 1'b1, 1'b0, 16'd99);
        expect_at(T + 100, "basic_done", 4'b0110, 1'b0, 1'b1, 16'd100);
        expect_at(T + 101, "basic_hold", 4'b0110, 1'b0, 1'b1, 16'd100);
        tick(); start = 1'b0; period = 32'h01010101; run_len = 16'd3;
        tick(101);

        // restart from DONE with all channels at half-period 1
        start = 1'b1; period = 32'h01010101; run_len = 16'd3; T = cyc + 1;
        expect_at(T,     "restart_T0", 4'b0000, 1'b1, 1'b0, 16'd0);
        expect_at(T + 1, "restart_T1", 4'b1111, 1'b1, 1'b0, 16'd1);
        expect_at(T + 2, "restart_T2", 4'b0000, 1'b1, 1'b0, 16'd2);
        expect_at(T + 3, "restart_done", 4'b1111, 1'b0, 1'b1, 16'd3);
        tick(); start = 1'b0; tick(4);

        // abort: stop sampled on the edge after T+37
        start = 1'b1; period = P_BASIC; run_len = 16'd100; T = cyc + 1;
        expect_at(T + 37, "abort_pre",  4'b1100, 1'b1, 1'b0, 16'd37);
        expect_at(T + 38, "abort_idle", 4'b0000, 1'b0, 1'b0, 16'd37);
        expect_at(T + 39, "abort_hold", 4'b0000, 1'b0, 1'b0, 16'd37);
        tick(); start = 1'b0; tick(37);
        stop = 1'b1; tick(); stop = 1'b0; tick();

        // run_len = 0 goes straight to DONE
        start = 1'b1; period = P_BASIC; run_len = 16'd0; T = cyc + 1;
        expect_at(T,     "len0_done", 4'b0000, 1'b0, 1'b1, 16'd0);
        expect_at(T + 1, "len0_hold", 4'b0000, 1'b0, 1'b1, 16'd0);
        tick(); start = 1'b0; tick();

        // disabled channels plus fastest channel, started from DONE
        start = 1'b1; period = 32'h00000001; run_len = 16'd7; T = cyc + 1;
        for (int k = 0; k < 7; k++)
            expect_at(T + k, "fast_run", {3'b000, k[0]}, 1'b1, 1'b0, 16'(k));
        expect_at(T + 7, "fast_done", 4'b0001, 1'b0, 1'b1, 16'd7);
        tick(); start = 1'b0; tick(8);

        // stop from DONE clears outputs
        stop = 1'b1; T = cyc + 1;
        expect_at(T, "done_stop", 4'b0000, 1'b0, 1'b0, 16'd7);
        tick(); stop = 1'b0; tick();

        // reset during a run
        start = 1'b1; period = P_BASIC; run_len = 16'd100; T = cyc + 1;
        expect_at(T + 1, "rst_pre",  4'b0000, 1'b1, 1'b0, 16'd1);
        expect_at(T + 2, "rst_mid",  4'b0000, 1'b0, 1'b0, 16'd0);
        expect_at(T + 3, "rst_post", 4'b0000, 1'b0, 1'b0, 16'd0);
        tick(); start = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0; tick(2);

        @(negedge clk); #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending: %0d expectations never checked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
